// File: rtl/datamemory_lsu_pkg.sv
// Shared types for the datamemory_lsu load/store unit: access sizes, FSM states
// and the size-to-byte-count helper.
package dm_pkg;

    typedef enum logic [1:0] {
        WORD  = 2'b00,
        HALF  = 2'b01,
        BYTE  = 2'b10,
        DWORD = 2'b11
    } dm_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    function automatic logic [3:0] dm_bytes(dm_size_e size);
        case (size)
            WORD:    return 4'd4;
            HALF:    return 4'd2;
            BYTE:    return 4'd1;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/datamemory_lsu_if.sv
// Request/response bundle for datamemory_lsu. Handshake: a request transfers on a
// rising edge where req_valid && req_ready; resp_valid is a one-cycle strobe.
interface datamemory_lsu_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/datamemory_lsu_sram.sv
// dm_sram: byte-enabled word array with one lane-enabled synchronous write port
// and one registered read port sharing a single word index.
module dm_sram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < DATA_W/8; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/datamemory_lsu.sv
// datamemory_lsu: MEM-stage load/store unit with sub-word lane select and extension.
// Define DM_MISALIGN_TRAP_EN to flag misaligned/illegal accesses instead of force-aligning.
import dm_pkg::*;

module datamemory_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    datamemory_lsu_if.slave  bus,
    output dm_state_e        state_dbg
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = DM_ADDRESS - OFF_W;
    localparam int DEPTH = 1 << IDX_W;

    dm_state_e         state, state_nxt;
    logic              accept;
    logic [OFF_W-1:0]  off, off_eff;
    logic [3:0]        n_eff;
    logic              err;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_word;
    logic [IDX_W-1:0]  idx;

    logic [3:0]        cap_n;
    logic              cap_signed;
    logic [OFF_W-1:0]  cap_off;
    logic              cap_err;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] rdata_q;

    // A request seen while reset is high must not reach the array.
    assign accept = bus.req_valid && (state == IDLE) && !reset;
    assign idx    = bus.req_addr[DM_ADDRESS-1:OFF_W];

    always_comb begin
        dm_size_e   sz;
        logic [3:0] n;
        sz  = dm_size_e'(bus.req_size);
        off = bus.req_addr[OFF_W-1:0];
`ifdef DM_MISALIGN_TRAP_EN
        n       = dm_bytes(sz);
        err     = ((4'(off) & (n - 4'd1)) != 4'd0) || (sz == DWORD && DATA_W == 32);
        off_eff = off;
`else
        if (sz == DWORD && DATA_W == 32) sz = WORD;
        n       = dm_bytes(sz);
        err     = 1'b0;
        off_eff = off & ~OFF_W'(n - 4'd1);
`endif
        n_eff = (n > 4'(LANES)) ? 4'(LANES) : n;
        for (int k = 0; k < LANES; k++) begin
            be[k] = (k >= int'(off_eff)) && (k < int'(off_eff) + int'(n_eff));
        end
        wdata_sh = bus.req_wdata << {off_eff, 3'b000};
    end

    dm_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .we    (accept && bus.req_we && !err),
        .be    (be),
        .re    (accept && !bus.req_we),
        .idx   (idx),
        .wdata (wdata_sh),
        .rdata (rd_word)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = bus.req_we ? RESP : LOAD;
            LOAD:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction from the word registered at acceptance.
    always_comb begin
        logic [DATA_W-1:0] sh;
        logic              sign;
        sh   = rd_word >> {cap_off, 3'b000};
        sign = 1'b0;
        for (int k = 1; k <= LANES; k++) begin
            if (int'(cap_n) == k) sign = cap_signed & sh[8*k-1];
        end
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < 8 * int'(cap_n)) ? sh[i] : sign;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cap_n      <= '0;
            cap_signed <= 1'b0;
            cap_off    <= '0;
            cap_err    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap_n      <= n_eff;
                cap_signed <= bus.req_signed;
                cap_off    <= off_eff;
                cap_err    <= err;
            end
            if (state == LOAD) rdata_q <= cap_err ? '0 : ext;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_err   = (state == RESP) && cap_err;
    assign bus.resp_rdata = rdata_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_datamemory_lsu.sv
// Directed bench for datamemory_lsu (DATA_W=32, DM_ADDRESS=9); honours DM_MISALIGN_TRAP_EN.
import dm_pkg::*;

module tb_datamemory_lsu;
    logic      clk = 1'b0;
    logic      reset;
    dm_state_e state_dbg;
    int        total = 0;
    int        bad   = 0;

    datamemory_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [8:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        chk("ready_before_req", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0;
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [8:0] addr,
                            input logic [31:0] wdata, input logic exp_err,
                            input logic [31:0] held_rdata);
        send(1'b1, size, 1'b0, addr, wdata);
        @(negedge clk);
        chk({tag, "_valid"}, bus.resp_valid, 1'b1);
        chk({tag, "_err"}, bus.resp_err, exp_err);
        chk({tag, "_rdata_held"}, bus.resp_rdata, held_rdata);
        @(negedge clk);
        chk({tag, "_ready_back"}, bus.req_ready, 1'b1);
        chk({tag, "_valid_drop"}, bus.resp_valid, 1'b0);
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [8:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
        send(1'b0, size, sgn, addr, 32'h0);
        @(negedge clk);
        chk({tag, "_no_early_valid"}, bus.resp_valid, 1'b0);
        chk({tag, "_state_load"}, state_dbg, LOAD);
        @(negedge clk);
        chk({tag, "_valid"}, bus.resp_valid, 1'b1);
        chk({tag, "_rdata"}, bus.resp_rdata, exp_data);
        chk({tag, "_err"}, bus.resp_err, exp_err);
        @(negedge clk);
        chk({tag, "_ready_back"}, bus.req_ready, 1'b1);
        chk({tag, "_valid_drop"}, bus.resp_valid, 1'b0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 9'h0;
        bus.req_wdata  = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_valid", bus.resp_valid, 1'b0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_err", bus.resp_err, 1'b0);
        chk("rst_state", state_dbg, IDLE);

        do_store("sw_10", 2'b00, 9'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_load("lw_10", 2'b00, 1'b0, 9'h10, 32'hDEADBEEF, 1'b0);
        do_load("lb_13", 2'b10, 1'b1, 9'h13, 32'hFFFFFFDE, 1'b0);
        do_load("lbu_13", 2'b10, 1'b0, 9'h13, 32'h000000DE, 1'b0);
        do_load("lh_12", 2'b01, 1'b1, 9'h12, 32'hFFFFDEAD, 1'b0);
        do_load("lhu_10", 2'b01, 1'b0, 9'h10, 32'h0000BEEF, 1'b0);
        do_load("lh_10", 2'b01, 1'b1, 9'h10, 32'hFFFFBEEF, 1'b0);
        do_load("lb_10", 2'b10, 1'b1, 9'h10, 32'hFFFFFFEF, 1'b0);
        do_load("lbu_11", 2'b10, 1'b0, 9'h11, 32'h000000BE, 1'b0);

        // Upper wdata bytes must be ignored by a byte store.
        do_store("sb_11", 2'b10, 9'h11, 32'hAAAAAA55, 1'b0, 32'h000000BE);
        do_load("lw_after_sb", 2'b00, 1'b0, 9'h10, 32'hDEAD55EF, 1'b0);

        do_store("sw_20", 2'b00, 9'h20, 32'hCAFEF00D, 1'b0, 32'hDEAD55EF);
        do_store("sh_22", 2'b01, 9'h22, 32'hFFFFA5A5, 1'b0, 32'hDEAD55EF);
        do_load("lw_after_sh", 2'b00, 1'b0, 9'h20, 32'hA5A5F00D, 1'b0);

`ifdef DM_MISALIGN_TRAP_EN
        do_store("sw_22_mis", 2'b00, 9'h22, 32'h12345678, 1'b1, 32'hA5A5F00D);
        do_load("lw_20_unchanged", 2'b00, 1'b0, 9'h20, 32'hA5A5F00D, 1'b0);
        do_load("lh_21_mis", 2'b01, 1'b1, 9'h21, 32'h00000000, 1'b1);
        do_load("ld_20_illegal", 2'b11, 1'b0, 9'h20, 32'h00000000, 1'b1);
        do_load("lw_20_after_err", 2'b00, 1'b0, 9'h20, 32'hA5A5F00D, 1'b0);
`else
        do_store("sw_22_align", 2'b00, 9'h22, 32'h12345678, 1'b0, 32'hA5A5F00D);
        do_load("lw_20_aligned", 2'b00, 1'b0, 9'h20, 32'h12345678, 1'b0);
        do_load("lh_21_align", 2'b01, 1'b1, 9'h21, 32'h00005678, 1'b0);
        do_load("lhu_23_align", 2'b01, 1'b0, 9'h23, 32'h00001234, 1'b0);
        do_load("ld_20_as_word", 2'b11, 1'b0, 9'h20, 32'h12345678, 1'b0);
`endif

        // Store presented while reset is high must not write.
        @(negedge clk);
        reset          = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_addr   = 9'h10;
        bus.req_wdata  = 32'h0BADF00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        chk("rst_store_no_resp", bus.resp_valid, 1'b0);
        do_load("lw_after_rst_store", 2'b00, 1'b0, 9'h10, 32'hDEAD55EF, 1'b0);

        // Reset while a load sits in LOAD aborts it without a response.
        send(1'b0, 2'b00, 1'b0, 9'h10, 32'h0);
        @(negedge clk);
        chk("abort_state_load", state_dbg, LOAD);
        reset = 1'b1;
        #1;
        chk("abort_ready_async", bus.req_ready, 1'b1);
        chk("abort_valid_async", bus.resp_valid, 1'b0);
        chk("abort_rdata_cleared", bus.resp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_resp_1", bus.resp_valid, 1'b0);
        chk("abort_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        chk("abort_no_resp_2", bus.resp_valid, 1'b0);
        chk("abort_state_idle", state_dbg, IDLE);
        do_load("lw_after_abort", 2'b00, 1'b0, 9'h10, 32'hDEAD55EF, 1'b0);

        // A back-to-back store then load to the same word sees the new data.
        do_store("sw_30", 2'b00, 9'h30, 32'h01020304, 1'b0, 32'hDEAD55EF);
        do_load("lw_30", 2'b00, 1'b0, 9'h30, 32'h01020304, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
